// File: rtl/lsu_mem_batcher_pkg.sv
// lsu_mem_batcher_pkg: cache-side geometry, shared types and dcache tag packing helpers.
package lsu_mem_batcher_pkg;
  localparam int NUM_LANES      = 4;
  localparam int NUM_BANKS      = 2;
  localparam int ADDR_WIDTH     = 30;
  localparam int WORD_SIZE      = 4;
  localparam int QUEUE_SIZE     = 8;
  localparam int TAG_WIDTH      = 8;
  localparam int NUM_BATCHES    = (NUM_LANES + NUM_BANKS - 1) / NUM_BANKS;
  localparam int BATCH_SEL_BITS = NUM_BATCHES > 1 ? $clog2(NUM_BATCHES) : 1;
  localparam int QID_BITS       = QUEUE_SIZE > 1 ? $clog2(QUEUE_SIZE) : 1;
  localparam int MEM_TAG_WIDTH  = TAG_WIDTH + BATCH_SEL_BITS;
  localparam int PAD_LANES      = NUM_BATCHES * NUM_BANKS;
  typedef logic [ADDR_WIDTH-1:0]     addr_t;
  typedef logic [WORD_SIZE*8-1:0]    word_t;
  typedef logic [WORD_SIZE-1:0]      ben_t;
  typedef logic [TAG_WIDTH-1:0]      tag_t;
  typedef logic [MEM_TAG_WIDTH-1:0]  mem_tag_t;
  typedef logic [BATCH_SEL_BITS-1:0] batch_t;
  typedef logic [QID_BITS-1:0]       qid_t;
  typedef enum logic {IDLE, ISSUE} state_t;
  function automatic mem_tag_t pack_mem_tag(input tag_t t, input batch_t b);
    return {t, b};
  endfunction
  function automatic batch_t mem_tag_batch(input mem_tag_t m);
    return m[BATCH_SEL_BITS-1:0];
  endfunction
  function automatic tag_t mem_tag_lsu(input mem_tag_t m);
    return m[MEM_TAG_WIDTH-1:BATCH_SEL_BITS];
  endfunction
  function automatic qid_t tag_qid(input tag_t t);
    return t[QID_BITS-1:0];
  endfunction
endpackage

// File: rtl/lsu_mem_batcher_if.sv
// lsu_mem_batcher_if: request/response bus, instanced once for the LSU side and once for the dcache side.
interface lsu_mem_batcher_if
  import lsu_mem_batcher_pkg::*;
#(
  parameter int LANES = NUM_LANES,
  parameter int TAG_W = TAG_WIDTH
) ();
  logic                   req_valid;
  logic                   req_rw;
  logic [LANES-1:0]       req_mask;
  addr_t [LANES-1:0]      req_addr;
  word_t [LANES-1:0]      req_data;
  ben_t [LANES-1:0]       req_byteen;
  logic [TAG_W-1:0]       req_tag;
  logic                   req_ready;
  logic                   rsp_valid;
  logic [LANES-1:0]       rsp_mask;
  word_t [LANES-1:0]      rsp_data;
  logic [TAG_W-1:0]       rsp_tag;
  logic                   rsp_ready;
  modport master (
    output req_valid, req_rw, req_mask, req_addr, req_data, req_byteen, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_mask, rsp_data, rsp_tag
  );
  modport slave (
    input  req_valid, req_rw, req_mask, req_addr, req_data, req_byteen, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_mask, rsp_data, rsp_tag
  );
endinterface

// File: rtl/lsu_mem_batcher_merge_table.sv
// lsu_rsp_merge_table: per-qid pending mask/tag/data; allocate on read issue, merge partial dcache responses.
module lsu_rsp_merge_table
  import lsu_mem_batcher_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          alloc,
  input  qid_t                          alloc_qid,
  input  logic [NUM_LANES-1:0]          alloc_mask,
  input  tag_t                          alloc_tag,
  input  logic                          merge,
  input  qid_t                          merge_qid,
  input  batch_t                        merge_batch,
  input  logic [NUM_BANKS-1:0]          merge_mask,
  input  word_t [NUM_BANKS-1:0]         merge_data,
  output logic                          done,
  output logic [NUM_LANES-1:0]          done_mask,
  output tag_t                          done_tag,
  output word_t [NUM_LANES-1:0]         done_data
);
  logic [QUEUE_SIZE-1:0][NUM_LANES-1:0] pend, orig_mask;
  tag_t [QUEUE_SIZE-1:0]                tag;
  word_t [QUEUE_SIZE-1:0][NUM_LANES-1:0] data;
  logic [PAD_LANES-1:0]                 cur_pend, new_pend;
  word_t [PAD_LANES-1:0]                new_data;
  logic [NUM_BANKS-1:0]                 stray;
  always_comb begin
    cur_pend = '0;
    cur_pend[NUM_LANES-1:0] = pend[merge_qid];
    new_data = '0;
    new_data[NUM_LANES-1:0] = data[merge_qid];
    stray = merge_mask & ~cur_pend[int'(merge_batch)*NUM_BANKS +: NUM_BANKS];
    new_pend = cur_pend;
    new_pend[int'(merge_batch)*NUM_BANKS +: NUM_BANKS] = cur_pend[int'(merge_batch)*NUM_BANKS +: NUM_BANKS] & ~merge_mask;
    for (int i = 0; i < NUM_BANKS; i++)
      if (merge_mask[i]) new_data[int'(merge_batch)*NUM_BANKS + i] = merge_data[i];
  end
  assign done      = merge && new_pend[NUM_LANES-1:0] == '0;
  assign done_mask = orig_mask[merge_qid];
  assign done_tag  = tag[merge_qid];
  assign done_data = new_data[NUM_LANES-1:0];
  // Allocate and merge address different qids in legal traffic, so both writes may land in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= '0;
      orig_mask <= '0;
      tag       <= '0;
      data      <= '0;
    end else begin
      if (alloc) begin
        pend[alloc_qid]      <= alloc_mask;
        orig_mask[alloc_qid] <= alloc_mask;
        tag[alloc_qid]       <= alloc_tag;
        data[alloc_qid]      <= '0;
      end
      if (merge) begin
        pend[merge_qid] <= new_pend[NUM_LANES-1:0];
        data[merge_qid] <= new_data[NUM_LANES-1:0];
      end
    end
  end
  a_alloc_free: assert property (@(posedge clk) disable iff (!rst_n) alloc |-> pend[alloc_qid] == '0);
  a_merge_live: assert property (@(posedge clk) disable iff (!rst_n) merge |-> (|cur_pend) && stray == '0);
endmodule

// File: rtl/lsu_mem_batcher.sv
// lsu_mem_batcher: splits full-width LSU requests into dcache-port batches and merges read responses back.
module lsu_mem_batcher
  import lsu_mem_batcher_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  lsu_mem_batcher_if.slave        lsu,
  lsu_mem_batcher_if.master       mem
);
  state_t                state;
  batch_t                batch_idx, first_b, next_b;
  logic                  zero_ack, has_next, mem_fire, alloc, done;
  logic [PAD_LANES-1:0]  mask_pad;
  addr_t [PAD_LANES-1:0] addr_pad;
  word_t [PAD_LANES-1:0] data_pad;
  ben_t [PAD_LANES-1:0]  ben_pad;
  logic [NUM_LANES-1:0]  done_mask;
  tag_t                  done_tag;
  word_t [NUM_LANES-1:0] done_data;
  // Lanes beyond NUM_LANES in the last batch read as zero, so they are masked off.
  always_comb begin
    mask_pad = '0;
    addr_pad = '0;
    data_pad = '0;
    ben_pad  = '0;
    mask_pad[NUM_LANES-1:0] = lsu.req_mask;
    addr_pad[NUM_LANES-1:0] = lsu.req_addr;
    data_pad[NUM_LANES-1:0] = lsu.req_data;
    ben_pad[NUM_LANES-1:0]  = lsu.req_byteen;
    first_b  = '0;
    next_b   = '0;
    has_next = 1'b0;
    for (int b = NUM_BATCHES - 1; b >= 0; b--)
      if (|mask_pad[b*NUM_BANKS +: NUM_BANKS]) begin
        first_b = batch_t'(b);
        if (b > int'(batch_idx)) begin
          next_b   = batch_t'(b);
          has_next = 1'b1;
        end
      end
  end
  assign mem.req_valid  = state == ISSUE;
  assign mem.req_rw     = lsu.req_rw;
  assign mem.req_mask   = mask_pad[int'(batch_idx)*NUM_BANKS +: NUM_BANKS];
  assign mem.req_addr   = addr_pad[int'(batch_idx)*NUM_BANKS +: NUM_BANKS];
  assign mem.req_data   = data_pad[int'(batch_idx)*NUM_BANKS +: NUM_BANKS];
  assign mem.req_byteen = ben_pad[int'(batch_idx)*NUM_BANKS +: NUM_BANKS];
  assign mem.req_tag    = pack_mem_tag(lsu.req_tag, batch_idx);
  assign mem_fire       = mem.req_valid & mem.req_ready;
  assign lsu.req_ready  = zero_ack | (mem_fire & ~has_next);
  assign alloc          = mem_fire & ~lsu.req_rw & (batch_idx == first_b);
  assign mem.rsp_ready  = ~lsu.rsp_valid | lsu.rsp_ready;
  // zero_ack blocks re-accepting the same zero-mask request during its ready cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      batch_idx <= '0;
      zero_ack  <= 1'b0;
    end else begin
      zero_ack <= 1'b0;
      if (state == IDLE) begin
        if (lsu.req_valid && !zero_ack) begin
          if (|lsu.req_mask) begin
            state     <= ISSUE;
            batch_idx <= first_b;
          end else zero_ack <= 1'b1;
        end
      end else if (mem_fire) begin
        batch_idx <= has_next ? next_b : '0;
        state     <= has_next ? ISSUE : IDLE;
      end
    end
  end
  lsu_rsp_merge_table u_table (
    .clk         (clk),
    .rst_n       (rst_n),
    .alloc       (alloc),
    .alloc_qid   (tag_qid(lsu.req_tag)),
    .alloc_mask  (lsu.req_mask),
    .alloc_tag   (lsu.req_tag),
    .merge       (mem.rsp_valid & mem.rsp_ready),
    .merge_qid   (tag_qid(mem_tag_lsu(mem.rsp_tag))),
    .merge_batch (mem_tag_batch(mem.rsp_tag)),
    .merge_mask  (mem.rsp_mask),
    .merge_data  (mem.rsp_data),
    .done        (done),
    .done_mask   (done_mask),
    .done_tag    (done_tag),
    .done_data   (done_data)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lsu.rsp_valid <= 1'b0;
      lsu.rsp_mask  <= '0;
      lsu.rsp_data  <= '0;
      lsu.rsp_tag   <= '0;
    end else if (done) begin
      lsu.rsp_valid <= 1'b1;
      lsu.rsp_mask  <= done_mask;
      lsu.rsp_data  <= done_data;
      lsu.rsp_tag   <= done_tag;
    end else if (lsu.rsp_ready) lsu.rsp_valid <= 1'b0;
  end
endmodule
